// File: rtl/serdes_link_ctrl.sv
// Serial framing / link bring-up controller: hunts for SYNC_WORD, qualifies it, locks, emits aligned words.
// Define SERDES_LINK_CTRL_ERRCNT_EN to build the saturating bad-sync counter on err_cnt.
module serdes_link_ctrl #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
  parameter int unsigned      FRAME_WORDS = 4,
  parameter int unsigned      LOCK_CNT    = 3,
  parameter int unsigned      LOSS_CNT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic             locked,
  output logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic             sof,
  output logic             scram_rst,
  output logic [7:0]       err_cnt
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = $clog2(FRAME_WORDS + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [IW-1:0] FRAME_LAST = IW'(FRAME_WORDS);
  localparam logic [GW-1:0] GOOD_PRE   = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_PRE   = MW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {IDLE, HUNT, CHECK, LOCKED} state_t;
  state_t state, state_nxt;

  // Only the older WIDTH-1 bits are stored; the incoming bit completes the word.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] nsr;
  logic [BW-1:0]    bitcnt, bitcnt_d;
  logic [IW-1:0]    widx, widx_d;
  logic [GW-1:0]    good, good_d;
  logic [MW-1:0]    miss, miss_d;
  logic             locked_d, word_valid_d, sof_d, scram_rst_d;
  logic [WIDTH-1:0] word_d;
  logic             done, sync_slot, slot_end, match;

  assign nsr       = {sr, din};
  assign match     = (nsr == SYNC_WORD);
  assign done      = (bitcnt == BIT_LAST);
  assign sync_slot = (widx == '0);
  assign slot_end  = done && sync_slot;

  always_ff @(posedge clk)
    if (rst || !en) state <= IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = HUNT;
      HUNT:   if (match) state_nxt = (LOCK_CNT == 1) ? LOCKED : CHECK;
      CHECK:  if (slot_end) state_nxt = !match ? HUNT : (good == GOOD_PRE) ? LOCKED : CHECK;
      LOCKED: if (slot_end && !match && miss == MISS_PRE) state_nxt = HUNT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bitcnt_d     = done ? '0 : bitcnt + BW'(1);
    widx_d       = !done ? widx : (widx == FRAME_LAST) ? '0 : widx + IW'(1);
    good_d       = good;
    miss_d       = miss;
    locked_d     = locked;
    word_d       = word;
    word_valid_d = 1'b0;
    sof_d        = 1'b0;
    scram_rst_d  = 1'b0;
    if (!en || state == IDLE) begin
      bitcnt_d = '0;
      widx_d   = '0;
      good_d   = '0;
      miss_d   = '0;
      locked_d = 1'b0;
      word_d   = '0;
    end else begin
      case (state)
        HUNT: if (match) begin
          bitcnt_d = '0;
          widx_d   = IW'(1);
          good_d   = GW'(1);
          miss_d   = '0;
          if (LOCK_CNT == 1) begin
            locked_d    = 1'b1;
            scram_rst_d = 1'b1;
          end
        end
        CHECK: if (slot_end) begin
          if (match) begin
            good_d = good + GW'(1);
            if (good == GOOD_PRE) begin
              locked_d    = 1'b1;
              scram_rst_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: if (done) begin
          if (sync_slot) begin
            if (match) begin
              miss_d      = '0;
              scram_rst_d = 1'b1;
            end else if (miss == MISS_PRE) begin
              miss_d   = '0;
              good_d   = '0;
              locked_d = 1'b0;
            end else begin
              miss_d = miss + MW'(1);
            end
          end else begin
            // Data slots are never compared, so SYNC_WORD here is ordinary payload.
            word_valid_d = 1'b1;
            word_d       = nsr;
            sof_d        = (widx == IW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      sr         <= '0;
      bitcnt     <= '0;
      widx       <= '0;
      good       <= '0;
      miss       <= '0;
      locked     <= 1'b0;
      word_valid <= 1'b0;
      word       <= '0;
      sof        <= 1'b0;
      scram_rst  <= 1'b0;
    end else begin
      if (en) sr <= nsr[WIDTH-2:0];
      bitcnt     <= bitcnt_d;
      widx       <= widx_d;
      good       <= good_d;
      miss       <= miss_d;
      locked     <= locked_d;
      word_valid <= word_valid_d;
      word       <= word_d;
      sof        <= sof_d;
      scram_rst  <= scram_rst_d;
    end

`ifdef SERDES_LINK_CTRL_ERRCNT_EN
  // Counts bad sync slots seen while locked, including the one that drops lock; only rst clears it.
  logic err_inc;
  assign err_inc = en && (state == LOCKED) && slot_end && !match;

  always_ff @(posedge clk)
    if (rst)                               err_cnt <= '0;
    else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`else
  assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Bench for serdes_link_ctrl: vector table, hand sequences, and randomized stream vs a frame-position model.
module tb_serdes_link_ctrl;
`ifdef SERDES_LINK_CTRL_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int W = 8, FW = 4, LOCK = 3;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0, rst, en, din;
  logic [1:0] locked_o, wv_o, sof_o, scr_o;
  logic [7:0] word_o [2];
  logic [7:0] err_o [2];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  serdes_link_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .locked(locked_o[0]), .word_valid(wv_o[0]), .word(word_o[0]),
    .sof(sof_o[0]), .scram_rst(scr_o[0]), .err_cnt(err_o[0]));

  serdes_link_ctrl #(.LOSS_CNT(255)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .locked(locked_o[1]), .word_valid(wv_o[1]), .word(word_o[1]),
    .sof(sof_o[1]), .scram_rst(scr_o[1]), .err_cnt(err_o[1]));

  // Reference model: tracks bits since the hunt match and derives slot position arithmetically.
  typedef enum int {M_IDLE, M_HUNT, M_CHECK, M_LOCK} mmode_t;
  mmode_t     m_mode [2];
  int         m_pos [2], m_good [2], m_miss [2], m_err [2];
  logic [7:0] m_hist [2], m_word [2];
  logic       m_locked [2], m_wv [2], m_sof [2], m_scr [2];
  int         loss_of [2] = '{2, 255};

  task automatic model_step(input int i, input logic r, e, d);
    int slot;
    m_wv[i] = 1'b0; m_sof[i] = 1'b0; m_scr[i] = 1'b0;
    if (r) begin
      m_mode[i] = M_IDLE; m_hist[i] = 8'h00; m_locked[i] = 1'b0; m_word[i] = 8'h00; m_err[i] = 0;
    end else if (!e) begin
      m_mode[i] = M_IDLE; m_locked[i] = 1'b0; m_word[i] = 8'h00;
    end else begin
      m_hist[i] = {m_hist[i][6:0], d};
      case (m_mode[i])
        M_IDLE: m_mode[i] = M_HUNT;
        M_HUNT: if (m_hist[i] == SYNC) begin
          m_pos[i] = 0; m_good[i] = 1; m_miss[i] = 0; m_mode[i] = M_CHECK;
        end
        default: begin
          m_pos[i]++;
          if (m_pos[i] % W == 0) begin
            slot = (m_pos[i] / W) % (FW + 1);
            if (slot != 0) begin
              if (m_mode[i] == M_LOCK) begin
                m_wv[i] = 1'b1; m_word[i] = m_hist[i]; m_sof[i] = (slot == 1);
              end
            end else if (m_mode[i] == M_CHECK) begin
              if (m_hist[i] == SYNC) begin
                m_good[i]++;
                if (m_good[i] == LOCK) begin m_mode[i] = M_LOCK; m_locked[i] = 1'b1; m_scr[i] = 1'b1; end
              end else m_mode[i] = M_HUNT;
            end else if (m_hist[i] == SYNC) begin
              m_miss[i] = 0; m_scr[i] = 1'b1;
            end else begin
              m_miss[i]++;
              if (m_err[i] < 255) m_err[i]++;
              if (m_miss[i] == loss_of[i]) begin m_mode[i] = M_HUNT; m_locked[i] = 1'b0; end
            end
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input int i);
    logic [19:0] act, exp;
    act = {locked_o[i], wv_o[i], sof_o[i], scr_o[i], err_o[i], wv_o[i] ? word_o[i] : 8'h00};
    exp = {m_locked[i], m_wv[i], m_sof[i], m_scr[i], ERR_EN ? 8'(m_err[i]) : 8'h00,
           m_wv[i] ? m_word[i] : 8'h00};
    chk($sformatf("model%0d@%0t", i, $time), 32'(act), 32'(exp));
  endtask

  task automatic tick(input logic r, input logic e, input logic d);
    rst = r; en = e; din = d;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, e, d);
      check_model(i);
    end
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) tick(1'b0, 1'b1, w[b]);
  endtask

  task automatic send_frame(input logic [7:0] s);
    send_byte(s); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
  endtask

  // Vector table: one word on the line, then outputs expected right after its last bit.
  typedef struct {
    logic [7:0] w;
    logic lk, sc, wv, sf;
    logic [7:0] dw;
    int err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [7:0] w, logic lk, logic sc, logic wv, logic sf, logic [7:0] dw, int err);
    vec_t v;
    v.w = w; v.lk = lk; v.sc = sc; v.wv = wv; v.sf = sf; v.dw = dw; v.err = err;
    tbl.push_back(v);
  endfunction
  function automatic void q_frame(logic [7:0] s, logic lk, int err);
    add(s, lk, 0, 0, 0, 0, err);
    add(8'h11, lk, 0, 0, 0, 0, err); add(8'h22, lk, 0, 0, 0, 0, err);
    add(8'h33, lk, 0, 0, 0, 0, err); add(8'h44, lk, 0, 0, 0, 0, err);
  endfunction
  function automatic void data4(logic [7:0] first, int err);
    add(first, 1, 0, 1, 1, first, err);
    add(8'h22, 1, 0, 1, 0, 8'h22, err); add(8'h33, 1, 0, 1, 0, 8'h33, err); add(8'h44, 1, 0, 1, 0, 8'h44, err);
  endfunction

  initial begin
    logic [63:0] r64;
    logic [44:0] v;
    bit ok;
    int k;

    q_frame(SYNC, 0, 0); q_frame(SYNC, 0, 0);
    add(SYNC, 1, 1, 0, 0, 0, 0);  data4(8'h11, 0);
    add(SYNC, 1, 1, 0, 0, 0, 0);  data4(8'hA5, 0);
    add(8'h00, 1, 0, 0, 0, 0, 1); data4(8'h11, 1);
    add(SYNC, 1, 1, 0, 0, 0, 1);  data4(8'h11, 1);
    add(8'h00, 1, 0, 0, 0, 0, 2); data4(8'h11, 2);
    add(8'h00, 0, 0, 0, 0, 0, 3);
    q_frame(SYNC, 0, 3); add(8'hA4, 0, 0, 0, 0, 0, 3);
    q_frame(SYNC, 0, 3); q_frame(SYNC, 0, 3);
    add(SYNC, 1, 1, 0, 0, 0, 3);  data4(8'h11, 3);

    tick(1'b1, 1'b0, 1'b0); tick(1'b1, 1'b1, 1'b0);
    chk("reset", 32'({locked_o[0], wv_o[0], sof_o[0], scr_o[0], err_o[0], word_o[0]}), 32'h0);

    // 37 junk bits with no sync pattern anywhere, including where they run into the first sync word
    do begin
      r64 = {$urandom(), $urandom()};
      v = {r64[36:0], SYNC};
      ok = 1'b1;
      for (int i = 1; i <= 37; i++) if (v[i +: 8] == SYNC) ok = 1'b0;
    end while (!ok);
    for (int b = 44; b >= 8; b--) tick(1'b0, 1'b1, v[b]);

    for (int n = 0; n < tbl.size(); n++) begin
      send_byte(tbl[n].w);
      chk($sformatf("vec%0d", n),
          32'({locked_o[0], scr_o[0], wv_o[0], sof_o[0], err_o[0], wv_o[0] ? word_o[0] : 8'h00}),
          32'({tbl[n].lk, tbl[n].sc, tbl[n].wv, tbl[n].sf, ERR_EN ? 8'(tbl[n].err) : 8'h00,
               tbl[n].wv ? tbl[n].dw : 8'h00}));
    end

    // One-cycle disable mid-lock: outputs drop, err_cnt survives, relock needs a full qualification.
    send_byte(SYNC);
    chk("resync_pulse", 32'(scr_o[0]), 32'd1);
    send_byte(8'h11);
    tick(1'b0, 1'b0, 1'b0);
    chk("dis_out", 32'({locked_o[0], wv_o[0], sof_o[0], scr_o[0]}), 32'h0);
    chk("dis_err", 32'(err_o[0]), ERR_EN ? 32'd3 : 32'd0);
    for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, 1'b0);
    send_frame(SYNC); send_frame(SYNC);
    chk("relock_early", 32'(locked_o[0]), 32'd0);
    send_byte(SYNC);
    chk("relock", 32'({locked_o[0], scr_o[0]}), 32'h3);

    send_byte(8'h11); send_byte(8'h22);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_out", 32'({locked_o[0], wv_o[0], sof_o[0], scr_o[0], err_o[0]}), 32'h0);

    // Saturation on the LOSS_CNT=255 instance: 300 bad syncs, a good one after every 100.
    for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, 1'b0);
    send_frame(SYNC); send_frame(SYNC); send_frame(SYNC);
    chk("sat_lock", 32'(locked_o[1]), 32'd1);
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h00);
      if (f % 100 == 99) send_frame(SYNC);
    end
    chk("sat_err", 32'(err_o[1]), ERR_EN ? 32'd255 : 32'd0);
    chk("sat_locked", 32'(locked_o[1]), 32'd1);

    for (int it = 0; it < 200; it++) begin
      k = $urandom_range(0, 19);
      if (k == 0) tick(1'b1, 1'b1, 1'b0);
      else if (k == 1) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else if (k <= 4) repeat ($urandom_range(1, 12)) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      else begin
        send_byte(k <= 16 ? SYNC : 8'($urandom()));
        for (int j = 0; j < FW; j++) send_byte(8'($urandom()));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
